// File: rtl/rob_commit_monitor_pkg.sv
// Shared types for the ROB commit monitor: snapshot FSM states, counter bundle
// and the saturating-add helper used by every accumulating counter.
package rob_commit_monitor_pkg;

    localparam int MAX_NUM_OF_COMMITS = 4;
    localparam int CNT_MAX_WIDTH      = 64;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_t;

    typedef logic [CNT_MAX_WIDTH-1:0] cnt_t;

    // Fields are sized for the widest supported counter; the monitor masks them
    // down to its own CNT_WIDTH so the unused upper bits are constant zero.
    typedef struct packed {
        cnt_t commits;
        cnt_t cycles;
        cnt_t stalls;
        cnt_t flushes;
    } cnt_bundle_t;

    function automatic cnt_t sat_add(input cnt_t cur, input cnt_t inc, input cnt_t max);
        logic [CNT_MAX_WIDTH:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        if (sum >= {1'b0, max}) begin
            return max;
        end
        return sum[CNT_MAX_WIDTH-1:0];
    endfunction

    function automatic cnt_bundle_t mask_bundle(input cnt_bundle_t b, input cnt_t m);
        cnt_bundle_t r;
        r.commits = b.commits & m;
        r.cycles  = b.cycles  & m;
        r.stalls  = b.stalls  & m;
        r.flushes = b.flushes & m;
        return r;
    endfunction

endpackage

// File: rtl/rob_commit_monitor_if.sv
// Commit/control/snapshot bundle between the ROB-side master and the monitor.
// Optional hist port exists only when COMMIT_HIST_EN is defined.
interface rob_commit_monitor_if
    import rob_commit_monitor_pkg::*;
#(
    parameter int COMMIT_WIDTH = MAX_NUM_OF_COMMITS,
    parameter int CNT_WIDTH    = 32,
    parameter int WINDOW_LOG2  = 6
) ();
    localparam int WC_W = WINDOW_LOG2 + $clog2(COMMIT_WIDTH + 1);

    logic [COMMIT_WIDTH-1:0] commit_valid;
    logic                    flush;
    logic                    enable;
    logic                    clear;
    // Snapshot handshake: snap_req is a level sampled only while idle; once
    // snap_valid is high the snapshot data stays frozen until snap_ack is sampled.
    logic                    snap_req;
    logic                    snap_ack;
    logic                    snap_valid;
    logic [CNT_WIDTH-1:0]    total_commits;
    logic [CNT_WIDTH-1:0]    total_cycles;
    logic [CNT_WIDTH-1:0]    stall_cycles;
    logic [CNT_WIDTH-1:0]    flush_count;
    logic [WC_W-1:0]         window_commits;
    logic                    saturated;
    logic [CNT_WIDTH-1:0]    snap_commits;
    logic [CNT_WIDTH-1:0]    snap_cycles;
    logic [CNT_WIDTH-1:0]    snap_stalls;
    logic [CNT_WIDTH-1:0]    snap_flushes;
    snap_state_t             dbg_snap_state;
`ifdef COMMIT_HIST_EN
    logic [(COMMIT_WIDTH+1)*CNT_WIDTH-1:0] hist;
`endif

    modport master (
        output commit_valid, flush, enable, clear, snap_req, snap_ack,
        input  snap_valid, total_commits, total_cycles, stall_cycles, flush_count,
               window_commits, saturated, snap_commits, snap_cycles, snap_stalls,
               snap_flushes, dbg_snap_state
`ifdef COMMIT_HIST_EN
        , input hist
`endif
    );

    modport slave (
        input  commit_valid, flush, enable, clear, snap_req, snap_ack,
        output snap_valid, total_commits, total_cycles, stall_cycles, flush_count,
               window_commits, saturated, snap_commits, snap_cycles, snap_stalls,
               snap_flushes, dbg_snap_state
`ifdef COMMIT_HIST_EN
        , output hist
`endif
    );

endinterface

// File: rtl/rob_commit_monitor_commit_popcount.sv
// Number of asserted commit lanes; lanes need not be contiguous.
module commit_popcount #(
    parameter int COMMIT_WIDTH = 4
) (
    input  logic [COMMIT_WIDTH-1:0]            i_valid,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0]  o_count
);
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_valid[i]);
        end
    end

endmodule

// File: rtl/rob_commit_monitor.sv
// ROB commit statistics: saturating live counters, throughput window and a
// req/ack frozen snapshot. Optional per-count histogram under COMMIT_HIST_EN.
module rob_commit_monitor
    import rob_commit_monitor_pkg::*;
#(
    parameter int COMMIT_WIDTH = MAX_NUM_OF_COMMITS,
    parameter int CNT_WIDTH    = 32,
    parameter int WINDOW_LOG2  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    rob_commit_monitor_if.slave  mon
);
    localparam int   NW      = $clog2(COMMIT_WIDTH + 1);
    localparam int   WC_W    = WINDOW_LOG2 + NW;
    localparam cnt_t CNT_MAX = (cnt_t'(1) << CNT_WIDTH) - cnt_t'(1);

    logic [NW-1:0]          w_n;
    cnt_bundle_t            r_live, r_snap, w_upd, w_live_nxt, w_snap_nxt;
    snap_state_t            r_state, w_state_nxt;
    logic                   w_snap_load;
    logic                   r_sat, w_sat_nxt, w_hit;
    logic [WINDOW_LOG2-1:0] r_timer, w_timer_nxt;
    logic [WC_W-1:0]        r_acc, w_acc_nxt, r_wc, w_wc_nxt;

    commit_popcount #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_popcount (
        .i_valid (mon.commit_valid),
        .o_count (w_n)
    );

    // w_upd is the next live state as if clear were low; snapshots load it.
    always_comb begin
        w_upd = r_live;
        if (mon.enable) begin
            w_upd.commits = sat_add(r_live.commits, cnt_t'(w_n), CNT_MAX);
            w_upd.cycles  = sat_add(r_live.cycles, cnt_t'(1), CNT_MAX);
            w_upd.stalls  = sat_add(r_live.stalls, cnt_t'(w_n == '0), CNT_MAX);
            w_upd.flushes = sat_add(r_live.flushes, cnt_t'(mon.flush), CNT_MAX);
        end
        w_upd      = mask_bundle(w_upd, CNT_MAX);
        w_live_nxt = mon.clear ? '0 : w_upd;
        w_snap_nxt = mask_bundle(w_snap_load ? w_upd : r_snap, CNT_MAX);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snap_load = 1'b0;
        case (r_state)
            SNAP_IDLE: begin
                if (mon.snap_req) begin
                    w_state_nxt = SNAP_HOLD;
                    w_snap_load = 1'b1;
                end
            end
            SNAP_HOLD: begin
                if (mon.snap_ack) begin
                    w_state_nxt = SNAP_IDLE;
                end
            end
            default: w_state_nxt = SNAP_IDLE;
        endcase
    end

    always_comb begin
        w_timer_nxt = r_timer;
        w_acc_nxt   = r_acc;
        w_wc_nxt    = r_wc;
        if (mon.clear) begin
            w_timer_nxt = '0;
            w_acc_nxt   = '0;
            w_wc_nxt    = '0;
        end else if (mon.enable) begin
            w_timer_nxt = r_timer + WINDOW_LOG2'(1);
            if (r_timer == '1) begin
                w_wc_nxt  = r_acc + WC_W'(w_n);
                w_acc_nxt = '0;
            end else begin
                w_acc_nxt = r_acc + WC_W'(w_n);
            end
        end
    end

`ifdef COMMIT_HIST_EN
    cnt_t r_hist     [COMMIT_WIDTH+1];
    cnt_t w_hist_nxt [COMMIT_WIDTH+1];
    logic w_hist_hit;

    always_comb begin
        w_hist_hit = 1'b0;
        for (int k = 0; k <= COMMIT_WIDTH; k++) begin
            w_hist_nxt[k] = r_hist[k];
            if (mon.enable) begin
                w_hist_nxt[k] = sat_add(r_hist[k], cnt_t'(int'(w_n) == k), CNT_MAX);
            end
            w_hist_nxt[k] = w_hist_nxt[k] & CNT_MAX;
            w_hist_hit    = w_hist_hit | (w_hist_nxt[k] == CNT_MAX);
            if (mon.clear) begin
                w_hist_nxt[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= COMMIT_WIDTH; k++) r_hist[k] <= '0;
        end else begin
            for (int k = 0; k <= COMMIT_WIDTH; k++) r_hist[k] <= w_hist_nxt[k];
        end
    end

    always_comb begin
        mon.hist = '0;
        for (int k = 0; k <= COMMIT_WIDTH; k++) begin
            mon.hist[k*CNT_WIDTH +: CNT_WIDTH] = r_hist[k][CNT_WIDTH-1:0];
        end
    end
`else
    logic w_hist_hit;
    assign w_hist_hit = 1'b0;
`endif

    assign w_hit = (w_upd.commits == CNT_MAX) | (w_upd.cycles == CNT_MAX) |
                   (w_upd.stalls == CNT_MAX) | (w_upd.flushes == CNT_MAX) | w_hist_hit;
    assign w_sat_nxt = mon.clear ? 1'b0 : (r_sat | w_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live  <= '0;
            r_snap  <= '0;
            r_state <= SNAP_IDLE;
            r_sat   <= 1'b0;
            r_timer <= '0;
            r_acc   <= '0;
            r_wc    <= '0;
        end else begin
            r_live  <= w_live_nxt;
            r_snap  <= w_snap_nxt;
            r_state <= w_state_nxt;
            r_sat   <= w_sat_nxt;
            r_timer <= w_timer_nxt;
            r_acc   <= w_acc_nxt;
            r_wc    <= w_wc_nxt;
        end
    end

    assign mon.total_commits  = r_live.commits[CNT_WIDTH-1:0];
    assign mon.total_cycles   = r_live.cycles[CNT_WIDTH-1:0];
    assign mon.stall_cycles   = r_live.stalls[CNT_WIDTH-1:0];
    assign mon.flush_count    = r_live.flushes[CNT_WIDTH-1:0];
    assign mon.snap_commits   = r_snap.commits[CNT_WIDTH-1:0];
    assign mon.snap_cycles    = r_snap.cycles[CNT_WIDTH-1:0];
    assign mon.snap_stalls    = r_snap.stalls[CNT_WIDTH-1:0];
    assign mon.snap_flushes   = r_snap.flushes[CNT_WIDTH-1:0];
    assign mon.window_commits = r_wc;
    assign mon.saturated      = r_sat;
    assign mon.snap_valid     = (r_state == SNAP_HOLD);
    assign mon.dbg_snap_state = r_state;

endmodule

// File: tb/tb_rob_commit_monitor.sv
// Directed bench: table of per-cycle vectors on a default-size monitor, plus
// hand sequences for snapshot, window and saturation on a small instance.
module tb_rob_commit_monitor;
    import rob_commit_monitor_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b;

    rob_commit_monitor_if #(.COMMIT_WIDTH(4), .CNT_WIDTH(32), .WINDOW_LOG2(6)) ifa ();
    rob_commit_monitor_if #(.COMMIT_WIDTH(4), .CNT_WIDTH(4),  .WINDOW_LOG2(2)) ifb ();

    rob_commit_monitor #(.COMMIT_WIDTH(4), .CNT_WIDTH(32), .WINDOW_LOG2(6)) dut_a (
        .clk(clk), .reset(rst_a), .mon(ifa.slave));
    rob_commit_monitor #(.COMMIT_WIDTH(4), .CNT_WIDTH(4), .WINDOW_LOG2(2)) dut_b (
        .clk(clk), .reset(rst_b), .mon(ifb.slave));

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [3:0] cv;
        logic       fl;
        logic       en;
        logic       clr;
        int         ec;
        int         ecy;
        int         est;
        int         efl;
    } vec_t;
    vec_t tbl[24];

    function automatic vec_t mk(input logic [3:0] cv, input logic fl, input logic en,
                                input logic clr, input int ec, input int ecy,
                                input int est, input int efl);
        vec_t v;
        v.cv = cv; v.fl = fl; v.en = en; v.clr = clr;
        v.ec = ec; v.ecy = ecy; v.est = est; v.efl = efl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_a(input logic [3:0] cv, input logic fl, input logic en,
                           input logic clr, input logic req, input logic ack);
        ifa.commit_valid = cv; ifa.flush = fl; ifa.enable = en;
        ifa.clear = clr; ifa.snap_req = req; ifa.snap_ack = ack;
    endtask

    task automatic drive_b(input logic [3:0] cv, input logic fl, input logic en,
                           input logic clr);
        ifb.commit_valid = cv; ifb.flush = fl; ifb.enable = en;
        ifb.clear = clr; ifb.snap_req = 1'b0; ifb.snap_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] e;
        int exp_b_c[5];
        int exp_b_s[5];

        tbl[0]  = mk(4'b1011, 0, 1, 0,  3,  1, 0, 0);
        tbl[1]  = mk(4'b1011, 0, 1, 0,  6,  2, 0, 0);
        tbl[2]  = mk(4'b1011, 0, 1, 0,  9,  3, 0, 0);
        tbl[3]  = mk(4'b1011, 0, 1, 0, 12,  4, 0, 0);
        tbl[4]  = mk(4'b1011, 0, 1, 0, 15,  5, 0, 0);
        tbl[5]  = mk(4'b1011, 0, 1, 0, 18,  6, 0, 0);
        tbl[6]  = mk(4'b1011, 0, 1, 0, 21,  7, 0, 0);
        tbl[7]  = mk(4'b1011, 0, 1, 0, 24,  8, 0, 0);
        tbl[8]  = mk(4'b1011, 0, 1, 0, 27,  9, 0, 0);
        tbl[9]  = mk(4'b1011, 0, 1, 0, 30, 10, 0, 0);
        tbl[10] = mk(4'b1111, 1, 1, 1,  0,  0, 0, 0);
        tbl[11] = mk(4'b0000, 1, 1, 0,  0,  1, 1, 1);
        tbl[12] = mk(4'b1111, 0, 1, 0,  4,  2, 1, 1);
        tbl[13] = mk(4'b0000, 0, 1, 0,  4,  3, 2, 1);
        tbl[14] = mk(4'b1111, 1, 1, 0,  8,  4, 2, 2);
        tbl[15] = mk(4'b0000, 0, 1, 0,  8,  5, 3, 2);
        tbl[16] = mk(4'b1111, 0, 1, 0, 12,  6, 3, 2);
        tbl[17] = mk(4'b0000, 0, 1, 0, 12,  7, 4, 2);
        tbl[18] = mk(4'b1111, 0, 1, 0, 16,  8, 4, 2);
        tbl[19] = mk(4'b1111, 1, 0, 0, 16,  8, 4, 2);
        tbl[20] = mk(4'b0000, 0, 0, 0, 16,  8, 4, 2);
        tbl[21] = mk(4'b0101, 0, 1, 0, 18,  9, 4, 2);
        tbl[22] = mk(4'b1000, 1, 1, 0, 19, 10, 4, 3);
        tbl[23] = mk(4'b0000, 0, 0, 1,  0,  0, 0, 0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(4'b0000, 0, 0, 0, 0, 0);
        drive_b(4'b0000, 0, 0, 0);
        #12;
        chk("rst_commits", ifa.total_commits, 0);
        chk("rst_cycles", ifa.total_cycles, 0);
        chk("rst_stalls", ifa.stall_cycles, 0);
        chk("rst_flushes", ifa.flush_count, 0);
        chk("rst_window", ifa.window_commits, 0);
        chk("rst_sat", ifa.saturated, 0);
        chk("rst_snap_valid", ifa.snap_valid, 0);
        chk("rst_snap_commits", ifa.snap_commits, 0);
        chk("rst_state", ifa.dbg_snap_state, SNAP_IDLE);
        chk("rst_b_commits", ifb.total_commits, 0);
`ifdef COMMIT_HIST_EN
        chk("rst_hist", ifa.hist, 0);
`endif
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // table-driven live-counter vectors on the default instance
        for (int i = 0; i < 24; i++) begin
            drive_a(tbl[i].cv, tbl[i].fl, tbl[i].en, tbl[i].clr, 0, 0);
            exp_q.push_back({32'(tbl[i].ec), 32'(tbl[i].ecy), 32'(tbl[i].est), 32'(tbl[i].efl)});
            tick();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_commits", i), ifa.total_commits, 64'(e[127:96]));
            chk($sformatf("vec%0d_cycles", i), ifa.total_cycles, 64'(e[95:64]));
            chk($sformatf("vec%0d_stalls", i), ifa.stall_cycles, 64'(e[63:32]));
            chk($sformatf("vec%0d_flushes", i), ifa.flush_count, 64'(e[31:0]));
`ifdef COMMIT_HIST_EN
            if (i == 18) begin
                chk("hist_bin0", ifa.hist[0*32 +: 32], 4);
                chk("hist_bin1", ifa.hist[1*32 +: 32], 0);
                chk("hist_bin3", ifa.hist[3*32 +: 32], 0);
                chk("hist_bin4", ifa.hist[4*32 +: 32], 4);
            end
`endif
        end
        chk("a_sat_after_table", ifa.saturated, 0);
        chk("a_window_idle", ifa.window_commits, 0);

        // snapshot together with clear: snapshot sees the un-cleared next state
        for (int i = 0; i < 5; i++) begin
            drive_a(4'b0001, 0, 1, 0, 0, 0);
            tick();
        end
        chk("pre_snap_commits", ifa.total_commits, 5);
        drive_a(4'b0001, 1, 1, 1, 1, 0);
        tick();
        chk("snap_valid_set", ifa.snap_valid, 1);
        chk("snap_commits", ifa.snap_commits, 6);
        chk("snap_cycles", ifa.snap_cycles, 6);
        chk("snap_stalls", ifa.snap_stalls, 0);
        chk("snap_flushes", ifa.snap_flushes, 1);
        chk("clear_commits", ifa.total_commits, 0);
        chk("clear_flushes", ifa.flush_count, 0);
        for (int i = 0; i < 3; i++) begin
            drive_a(4'b0001, 0, 1, 0, 1, 0);
            tick();
        end
        chk("hold_live_commits", ifa.total_commits, 3);
        chk("hold_snap_commits", ifa.snap_commits, 6);
        chk("hold_state", ifa.dbg_snap_state, SNAP_HOLD);
        drive_a(4'b0001, 0, 1, 0, 0, 1);
        tick();
        chk("ack_drops_valid", ifa.snap_valid, 0);
        chk("ack_keeps_data", ifa.snap_commits, 6);
        drive_a(4'b0001, 0, 1, 0, 0, 1);
        tick();
        chk("ack_in_idle", ifa.snap_valid, 0);
        drive_a(4'b0000, 0, 1, 0, 1, 0);
        tick();
        chk("resnap_valid", ifa.snap_valid, 1);
        chk("resnap_commits", ifa.snap_commits, 5);
        chk("resnap_cycles", ifa.snap_cycles, 6);
        chk("resnap_stalls", ifa.snap_stalls, 1);
        chk("resnap_flushes", ifa.snap_flushes, 0);

        // asynchronous reset while holding a snapshot
        drive_a(4'b0001, 0, 1, 0, 0, 0);
        #2;
        rst_a = 1'b1;
        #1;
        chk("areset_snap_valid", ifa.snap_valid, 0);
        chk("areset_snap_commits", ifa.snap_commits, 0);
        chk("areset_commits", ifa.total_commits, 0);
        chk("areset_cycles", ifa.total_cycles, 0);
        @(negedge clk);
        rst_a = 1'b0;

        // ack and req together in HOLD: back to IDLE, request dropped
        drive_a(4'b0001, 0, 1, 0, 1, 0);
        tick();
        chk("hold2_valid", ifa.snap_valid, 1);
        chk("hold2_commits", ifa.snap_commits, 1);
        drive_a(4'b0001, 0, 1, 0, 1, 1);
        tick();
        chk("ackreq_valid", ifa.snap_valid, 0);
        drive_a(4'b0001, 0, 1, 0, 0, 0);
        tick();
        chk("ackreq_no_resnap", ifa.snap_valid, 0);
        chk("ackreq_snap_frozen", ifa.snap_commits, 1);
        chk("ackreq_live", ifa.total_commits, 3);

        // window of 4 cycles on the small instance, with an enable-low gap
        for (int i = 1; i <= 6; i++) begin
            drive_b(4'b0011, 0, 1, 0);
            tick();
            chk($sformatf("win_c%0d", i), ifb.window_commits, (i < 4) ? 0 : 8);
        end
        chk("win_commits6", ifb.total_commits, 12);
        for (int i = 0; i < 3; i++) begin
            drive_b(4'b1111, 1, 0, 0);
            tick();
            chk($sformatf("freeze%0d_window", i), ifb.window_commits, 8);
        end
        chk("freeze_commits", ifb.total_commits, 12);
        chk("freeze_cycles", ifb.total_cycles, 6);
        chk("freeze_flushes", ifb.flush_count, 0);
        drive_b(4'b0111, 0, 1, 0);
        tick();
        chk("win_c7", ifb.window_commits, 8);
        chk("sat_hit_commits", ifb.total_commits, 15);
        chk("sat_hit_flag", ifb.saturated, 1);
        drive_b(4'b0111, 0, 1, 0);
        tick();
        chk("win_c8", ifb.window_commits, 10);
        chk("sat_hold_commits", ifb.total_commits, 15);
        chk("win_cycles8", ifb.total_cycles, 8);

        // clear, then saturate a 4-bit counter with full commit cycles
        drive_b(4'b0000, 0, 1, 1);
        tick();
        chk("clr_b_commits", ifb.total_commits, 0);
        chk("clr_b_sat", ifb.saturated, 0);
        chk("clr_b_window", ifb.window_commits, 0);
        exp_b_c = '{4, 8, 12, 15, 15};
        exp_b_s = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            drive_b(4'b1111, 0, 1, 0);
            tick();
            chk($sformatf("satseq%0d_commits", i), ifb.total_commits, 64'(exp_b_c[i]));
            chk($sformatf("satseq%0d_flag", i), ifb.saturated, 64'(exp_b_s[i]));
        end
        chk("satseq_window", ifb.window_commits, 16);
        drive_b(4'b0000, 0, 1, 1);
        tick();
        chk("clr2_b_commits", ifb.total_commits, 0);
        chk("clr2_b_sat", ifb.saturated, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
